// File: rtl/sram_access_ctrl.sv
// Command-driven SRAM beat sequencer: write/read bursts of 4-lane beats into the long bank or a short bank.
// Writes issue in the cycle wr_valid_i is seen and stall without it; reads issue every cycle and return RdLatency cycles later.
module sram_access_ctrl #(
   parameter int SfpWidth  = 16,
   parameter int AddrWidth = 7,
   parameter int LenWidth  = 8,
   parameter int RdLatency = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic [1:0]              cmd_bank_i,
   input  logic [AddrWidth-1:0]    cmd_base_i,
   input  logic [AddrWidth-1:0]    cmd_stride_i,
   input  logic [LenWidth-1:0]     cmd_len_i,
   input  logic                    wr_valid_i,
   output logic                    wr_ready_o,
   input  logic [4*SfpWidth-1:0]   wr_dr_i,
   input  logic [4*SfpWidth-1:0]   wr_di_i,
   output logic [3:0]              sram_wen_o,
   output logic [1:0]              sram_di_en_o,
   output logic [1:0]              sram_do_en_o,
   output logic [4*AddrWidth-1:0]  sram_addr_o,
   output logic [4*SfpWidth-1:0]   sram_dr_o,
   output logic [4*SfpWidth-1:0]   sram_di_o,
   input  logic [4*SfpWidth-1:0]   sram_dr_i,
   input  logic [4*SfpWidth-1:0]   sram_di_i,
   output logic                    rd_valid_o,
   output logic                    rd_last_o,
   output logic [4*SfpWidth-1:0]   rd_dr_o,
   output logic [4*SfpWidth-1:0]   rd_di_o,
   output logic                    busy_o,
   output logic                    done_o
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             bank_q, bank_d;
   logic [AddrWidth-1:0]   stride_q, stride_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [LenWidth-1:0]    len_q, len_d;
   logic [LenWidth-1:0]    beat_q, beat_d;
   logic                   done_q, done_d;
   logic [1:0]             do_en_q, do_en_d;
   logic [RdLatency-1:0]   vld_sr_q, last_sr_q;
   logic                   issue, issue_last, rd_last, last_beat;
   logic [AddrWidth-1:0]   addr_step;

   // Short banks wrap at 32 entries; the long bank wraps at the full address width.
   function automatic logic [AddrWidth-1:0] bank_mask(input logic [1:0] b);
      logic [AddrWidth-1:0] m;
      m = '1;
      if (b != 2'd0) m = AddrWidth'(5'h1F);
      return m;
   endfunction

   assign rd_last   = last_sr_q[RdLatency-1];
   assign last_beat = (beat_q == len_q - LenWidth'(1));
   assign addr_step = (addr_q + stride_q) & bank_mask(bank_q);

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      stride_d     = stride_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      done_d       = 1'b0;
      do_en_d      = do_en_q;
      issue        = 1'b0;
      issue_last   = 1'b0;
      cmd_ready_o  = 1'b0;
      wr_ready_o   = 1'b0;
      sram_wen_o   = '0;
      sram_di_en_o = '0;
      sram_do_en_o = do_en_q;
      sram_addr_o  = '0;
      sram_dr_o    = '0;
      sram_di_o    = '0;
      unique case (state_q)
         IDLE: begin
            cmd_ready_o = !rst_i;
            if (cmd_valid_i) begin
               bank_d   = cmd_bank_i;
               stride_d = cmd_stride_i;
               len_d    = cmd_len_i;
               beat_d   = '0;
               addr_d   = cmd_base_i & bank_mask(cmd_bank_i);
               if (cmd_len_i == '0) done_d  = 1'b1;
               else                 state_d = cmd_write_i ? WRITE : READ;
            end
         end
         WRITE: begin
            wr_ready_o   = 1'b1;
            sram_di_en_o = bank_q;
            sram_addr_o  = {4{addr_q}};
            if (wr_valid_i) begin
               sram_wen_o[bank_q] = 1'b1;
               sram_dr_o = wr_dr_i;
               sram_di_o = wr_di_i;
               beat_d    = beat_q + LenWidth'(1);
               addr_d    = addr_step;
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            sram_di_en_o = bank_q;
            sram_do_en_o = bank_q;
            do_en_d      = bank_q;
            sram_addr_o  = {4{addr_q}};
            issue        = 1'b1;
            beat_d       = beat_q + LenWidth'(1);
            addr_d       = addr_step;
            if (last_beat) begin
               issue_last = 1'b1;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            // The final beat returns in the last drain cycle, so leave as it emerges.
            if (rd_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         bank_q    <= '0;
         stride_q  <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         done_q    <= 1'b0;
         do_en_q   <= '0;
         vld_sr_q  <= '0;
         last_sr_q <= '0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         stride_q  <= stride_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         done_q    <= done_d;
         do_en_q   <= do_en_d;
         vld_sr_q  <= (vld_sr_q << 1) | RdLatency'(issue);
         last_sr_q <= (last_sr_q << 1) | RdLatency'(issue_last);
      end
   end

   assign rd_valid_o = vld_sr_q[RdLatency-1];
   assign rd_last_o  = rd_last;
   assign rd_dr_o    = rd_valid_o ? sram_dr_i : '0;
   assign rd_di_o    = rd_valid_o ? sram_di_i : '0;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q | rd_last;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized bench for sram_access_ctrl: a bench-side SRAM stands in for sram_system and a
// golden memory plus arithmetic address rules give every expected value.
`timescale 1ns/1ps
module tb_sram_access_ctrl;
   localparam int SW  = 16;
   localparam int AW  = 7;
   localparam int LW  = 8;
   localparam int LAT = 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [1:0]       cmd_bank_i;
   logic [AW-1:0]    cmd_base_i, cmd_stride_i;
   logic [LW-1:0]    cmd_len_i;
   logic             wr_valid_i, wr_ready_o;
   logic [4*SW-1:0]  wr_dr_i, wr_di_i;
   logic [3:0]       sram_wen_o;
   logic [1:0]       sram_di_en_o, sram_do_en_o;
   logic [4*AW-1:0]  sram_addr_o;
   logic [4*SW-1:0]  sram_dr_o, sram_di_o, sram_dr_i, sram_di_i;
   logic             rd_valid_o, rd_last_o, busy_o, done_o;
   logic [4*SW-1:0]  rd_dr_o, rd_di_o;

   int n_chk = 0;
   int n_err = 0;
   int last_rd_bank = 0;
   logic [8*SW-1:0] gold [4][128];

   always #5 clk_i = ~clk_i;

   sram_access_ctrl #(.SfpWidth(SW), .AddrWidth(AW), .LenWidth(LW), .RdLatency(LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_bank_i(cmd_bank_i), .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i),
      .cmd_len_i(cmd_len_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_dr_i(wr_dr_i), .wr_di_i(wr_di_i),
      .sram_wen_o(sram_wen_o), .sram_di_en_o(sram_di_en_o), .sram_do_en_o(sram_do_en_o),
      .sram_addr_o(sram_addr_o), .sram_dr_o(sram_dr_o), .sram_di_o(sram_di_o),
      .sram_dr_i(sram_dr_i), .sram_di_i(sram_di_i),
      .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o), .rd_dr_o(rd_dr_o), .rd_di_o(rd_di_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   // Stand-in SRAM: per-bank, per-lane storage with one cycle of read latency.
   logic [SW-1:0] env_r [4][4][128];
   logic [SW-1:0] env_i [4][4][128];
   always @(posedge clk_i) begin
      for (int l = 0; l < 4; l++) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_wen_o[b]) begin
               env_r[b][l][sram_addr_o[l*AW +: AW]] <= sram_dr_o[l*SW +: SW];
               env_i[b][l][sram_addr_o[l*AW +: AW]] <= sram_di_o[l*SW +: SW];
            end
         end
         sram_dr_i[l*SW +: SW] <= env_r[sram_do_en_o][l][sram_addr_o[l*AW +: AW]];
         sram_di_i[l*SW +: SW] <= env_i[sram_do_en_o][l][sram_addr_o[l*AW +: AW]];
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input int bank, input int base, input int stride, input int k);
      int sz;
      sz = (bank == 0) ? 128 : 32;
      return AW'((base + k * stride) % sz);
   endfunction

   function automatic logic [4*AW-1:0] lanes(input logic [AW-1:0] a);
      return {4{a}};
   endfunction

   // Each task starts and ends 1 ns after a rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue_cmd(input bit wr, input int bank, input int base, input int stride, input int len);
      cmd_valid_i  = 1'b1;
      cmd_write_i  = wr;
      cmd_bank_i   = 2'(bank);
      cmd_base_i   = AW'(base);
      cmd_stride_i = AW'(stride);
      cmd_len_i    = LW'(len);
      @(negedge clk_i);
      chk("cmd_ready", cmd_ready_o, 1);
      chk("busy_idle", busy_o, 0);
      chk("idle_do_en_hold", sram_do_en_o, last_rd_bank);
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic len0_tail();
      @(negedge clk_i);
      chk("len0_done", done_o, 1);
      chk("len0_ready", cmd_ready_o, 1);
      chk("len0_wen", sram_wen_o, 0);
      chk("len0_busy", busy_o, 0);
      tick();
      @(negedge clk_i);
      chk("len0_done_once", done_o, 0);
      tick();
   endtask

   task automatic run_write(input int bank, input int base, input int stride, input int len,
                            input logic [31:0] vpat);
      int k, c;
      logic v;
      logic [AW-1:0] ea;
      issue_cmd(1'b1, bank, base, stride, len);
      if (len == 0) begin
         len0_tail();
         return;
      end
      k = 0;
      c = 0;
      while (k < len && c < 8 * len + 16) begin
         if (vpat != 0) v = (c < 32) ? vpat[c] : 1'b1;
         else           v = ($urandom_range(0, 9) < 7);
         wr_valid_i = v;
         wr_dr_i    = {$urandom, $urandom};
         wr_di_i    = {$urandom, $urandom};
         ea = exp_addr(bank, base, stride, k);
         @(negedge clk_i);
         chk("wr_ready", wr_ready_o, 1);
         chk("wr_addr", sram_addr_o, lanes(ea));
         chk("wr_di_en", sram_di_en_o, bank);
         chk("wr_do_en_hold", sram_do_en_o, last_rd_bank);
         chk("wr_done_low", done_o, 0);
         if (v) begin
            chk("wr_wen", sram_wen_o, 4'b0001 << bank);
            chk("wr_dr", sram_dr_o, wr_dr_i);
            chk("wr_di", sram_di_o, wr_di_i);
            gold[bank][ea] = {wr_dr_i, wr_di_i};
            k++;
         end else begin
            chk("wr_wen_stall", sram_wen_o, 0);
         end
         tick();
         c++;
      end
      wr_valid_i = 1'b0;
      if (k < len) chk("wr_budget", k, len);
      @(negedge clk_i);
      chk("wr_done", done_o, 1);
      chk("wr_ready_after", wr_ready_o, 0);
      chk("wr_cmd_ready_after", cmd_ready_o, 1);
      chk("wr_wen_after", sram_wen_o, 0);
      tick();
   endtask

   task automatic run_read(input int bank, input int base, input int stride, input int len);
      bit ev, el;
      logic [AW-1:0] ea;
      issue_cmd(1'b0, bank, base, stride, len);
      if (len == 0) begin
         len0_tail();
         return;
      end
      for (int c = 0; c <= len + LAT; c++) begin
         @(negedge clk_i);
         ev = (c >= LAT) && (c < len + LAT);
         el = (c == len + LAT - 1);
         if (c < len) begin
            chk("rd_addr", sram_addr_o, lanes(exp_addr(bank, base, stride, c)));
            chk("rd_di_en", sram_di_en_o, bank);
         end
         chk("rd_wen", sram_wen_o, 0);
         chk("rd_wr_ready", wr_ready_o, 0);
         chk("rd_do_en", sram_do_en_o, bank);
         chk("rd_valid", rd_valid_o, ev);
         chk("rd_last", rd_last_o, el);
         chk("rd_done", done_o, el);
         chk("rd_busy", busy_o, c < len + LAT);
         chk("rd_cmd_ready", cmd_ready_o, c == len + LAT);
         if (ev) begin
            ea = exp_addr(bank, base, stride, c - LAT);
            chk("rd_dr_data", rd_dr_o, gold[bank][ea][8*SW-1:4*SW]);
            chk("rd_di_data", rd_di_o, gold[bank][ea][4*SW-1:0]);
         end
         tick();
      end
      last_rd_bank = bank;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_rd_valid"}, rd_valid_o, 0);
      chk({tag, "_rd_last"}, rd_last_o, 0);
      chk({tag, "_addr"}, sram_addr_o, 0);
      chk({tag, "_wen"}, sram_wen_o, 0);
      chk({tag, "_do_en"}, sram_do_en_o, 0);
      chk({tag, "_di_en"}, sram_di_en_o, 0);
      chk({tag, "_wr_ready"}, wr_ready_o, 0);
   endtask

   initial begin
      int bank, len;
      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_write_i  = 1'b0;
      cmd_bank_i   = '0;
      cmd_base_i   = '0;
      cmd_stride_i = '0;
      cmd_len_i    = '0;
      wr_valid_i   = 1'b0;
      wr_dr_i      = '0;
      wr_di_i      = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_outputs("reset");
      tick();
      rst_i = 1'b0;
      tick();

      // Fill every bank so later reads see known contents.
      run_write(0, 0, 1, 128, 32'h0);
      for (int b = 1; b < 4; b++) run_write(b, 0, 1, 32, 32'h0);

      run_write(0, 10, 1, 4, 32'b11101);
      run_read(0, 10, 1, 4);
      run_write(2, 30, 1, 4, 32'h0);
      run_read(2, 30, 1, 4);
      run_read(0, 120, 8, 3);
      run_write(1, 5, 3, 0, 32'h0);
      run_read(3, 7, 1, 0);

      // Reset asserted during the second beat of an 8-beat read.
      issue_cmd(1'b0, 1, 3, 1, 8);
      tick();
      rst_i = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick();
      @(negedge clk_i);
      check_reset_outputs("midrst_hold");
      tick();
      rst_i = 1'b0;
      last_rd_bank = 0;
      tick();
      run_write(1, 3, 1, 2, 32'h0);
      run_read(1, 3, 1, 2);

      for (int i = 0; i < 40; i++) begin
         bank = $urandom_range(0, 3);
         len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
         if ($urandom_range(0, 1) == 1)
            run_write(bank, $urandom_range(0, 127), $urandom_range(0, 127), len, 32'h0);
         else
            run_read(bank, $urandom_range(0, 127), $urandom_range(0, 127), len);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
